aes_inv_core_top: RTL and testbench



---
 rtl/aes_inv_core_top.sv | 275 +++++++++++++++++++++++++++
 tb/tb_aes_inv_core_top.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_core_top.sv
// aes_inv_core_top: iterative AES-128 decryption, one inverse round per clock.
// Optional key cache enabled by defining AES_INV_KEY_CACHE_EN.
module aes_inv_core_top #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_BLK  = 4,
  parameter int CNT_SIZE = 4,
  parameter int NUM_RND  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [RND_SIZE-1:0] i_cypher,
  input  logic [RND_SIZE-1:0] i_key,
  output logic                o_valid,
  output logic [RND_SIZE-1:0] o_msg,
  output logic                o_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } fsm_t;

  localparam int NUM_BYTES = RND_SIZE / 8;
  localparam logic [CNT_SIZE-1:0] CNT_ONE  = CNT_SIZE'(1);
  localparam logic [CNT_SIZE-1:0] CNT_ZERO = CNT_SIZE'(0);
  localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(NUM_RND);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? (p ^ x) : p;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Inverse in GF(2^8) as a^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    y = gf_inv(a);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] z;
    z = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(z);
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_SIZE-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [WRD_SIZE-1:0] inv_mix_col(input logic [WRD_SIZE-1:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  fsm_t                fsm_r, fsm_nxt;
  logic [RND_SIZE-1:0] data_r, data_nxt;
  logic [RND_SIZE-1:0] key_r, key_nxt;
  logic [CNT_SIZE-1:0] cnt_r, cnt_nxt;
  logic [RND_SIZE-1:0] msg_r, msg_nxt;
  logic                valid_r, valid_nxt;
  logic                ready_r, busy_r;

  logic [WRD_SIZE-1:0] kw_s [NUM_BLK];
  logic [WRD_SIZE-1:0] sub_in_s, sub_rot_s, sub_out_s, rcon_w_s;
  logic [WRD_SIZE-1:0] f0_s, f1_s, f2_s, f3_s;
  logic [RND_SIZE-1:0] fwd_key_s, bwd_key_s;
  logic [RND_SIZE-1:0] isb_s, ark_s, imc_s, round_s;
  logic                hit_s;
  logic [RND_SIZE-1:0] cache_k10_s;

  // Key schedule: the four forward S-boxes serve both the forward and backward step.
  always_comb begin
    for (int i = 0; i < NUM_BLK; i++) begin
      kw_s[i] = key_r[RND_SIZE-1-WRD_SIZE*i -: WRD_SIZE];
    end
    if (fsm_r == KEYEXP) begin
      sub_in_s = kw_s[3];
    end else begin
      sub_in_s = kw_s[3] ^ kw_s[2];
    end
    sub_rot_s = {sub_in_s[WRD_SIZE-9:0], sub_in_s[WRD_SIZE-1 -: 8]};
    sub_out_s = '0;
    for (int i = 0; i < WRD_SIZE / 8; i++) begin
      sub_out_s[WRD_SIZE-1-8*i -: 8] = sbox(sub_rot_s[WRD_SIZE-1-8*i -: 8]);
    end
    rcon_w_s  = {rcon(cnt_r), {(WRD_SIZE-8){1'b0}}};
    f0_s      = kw_s[0] ^ sub_out_s ^ rcon_w_s;
    f1_s      = kw_s[1] ^ f0_s;
    f2_s      = kw_s[2] ^ f1_s;
    f3_s      = kw_s[3] ^ f2_s;
    fwd_key_s = {f0_s, f1_s, f2_s, f3_s};
    bwd_key_s = {kw_s[0] ^ sub_out_s ^ rcon_w_s, kw_s[1] ^ kw_s[0],
                 kw_s[2] ^ kw_s[1], kw_s[3] ^ kw_s[2]};
  end

  // Inverse round data path: InvShiftRows+InvSubBytes, AddRoundKey, InvMixColumns.
  always_comb begin
    int src;
    src   = 0;
    isb_s = '0;
    imc_s = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      src = (i % NUM_BLK) + NUM_BLK * (((i / NUM_BLK) - (i % NUM_BLK) + NUM_BLK) % NUM_BLK);
      isb_s[RND_SIZE-1-8*i -: 8] = inv_sbox(data_r[RND_SIZE-1-8*src -: 8]);
    end
    ark_s = isb_s ^ key_r;
    for (int c = 0; c < NUM_BLK; c++) begin
      imc_s[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE] = inv_mix_col(ark_s[RND_SIZE-1-WRD_SIZE*c -: WRD_SIZE]);
    end
    if (cnt_r == CNT_LAST) begin
      round_s = data_r ^ key_r;
    end else if (cnt_r == CNT_ZERO) begin
      round_s = ark_s;
    end else begin
      round_s = imc_s;
    end
  end

`ifdef AES_INV_KEY_CACHE_EN
  logic [RND_SIZE-1:0] cache_key_r, cache_k10_r;
  logic                cache_vld_r;

  // Cache lookup against the key presented at accept time.
  always_comb begin
    hit_s       = cache_vld_r && (i_key == cache_key_r);
    cache_k10_s = cache_k10_r;
  end

  // Key cache: remember the key on a miss, publish its K10 once expansion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key_r <= '0;
      cache_k10_r <= '0;
      cache_vld_r <= 1'b0;
    end else if ((fsm_r == IDLE) && i_en && !hit_s) begin
      cache_key_r <= i_key;
      cache_vld_r <= 1'b0;
    end else if ((fsm_r == KEYEXP) && (cnt_r == CNT_LAST)) begin
      cache_k10_r <= fwd_key_s;
      cache_vld_r <= 1'b1;
    end else begin
      cache_vld_r <= cache_vld_r;
    end
  end
`else
  // Without the cache every accept takes the key-expansion path.
  always_comb begin
    hit_s       = 1'b0;
    cache_k10_s = '0;
  end
`endif

  // Next-state and datapath register selection.
  always_comb begin
    fsm_nxt   = fsm_r;
    data_nxt  = data_r;
    key_nxt   = key_r;
    cnt_nxt   = cnt_r;
    msg_nxt   = msg_r;
    valid_nxt = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (i_en) begin
          data_nxt = i_cypher;
          if (hit_s) begin
            key_nxt = cache_k10_s;
            cnt_nxt = CNT_LAST;
            fsm_nxt = ROUND;
          end else begin
            key_nxt = i_key;
            cnt_nxt = CNT_ONE;
            fsm_nxt = KEYEXP;
          end
        end else begin
          fsm_nxt = IDLE;
        end
      end
      KEYEXP: begin
        key_nxt = fwd_key_s;
        if (cnt_r == CNT_LAST) begin
          fsm_nxt = ROUND;
        end else begin
          cnt_nxt = cnt_r + CNT_ONE;
        end
      end
      ROUND: begin
        data_nxt = round_s;
        if (cnt_r == CNT_ZERO) begin
          msg_nxt   = ark_s;
          valid_nxt = 1'b1;
          fsm_nxt   = DONE;
        end else begin
          key_nxt = bwd_key_s;
          cnt_nxt = cnt_r - CNT_ONE;
        end
      end
      DONE:    fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r   <= IDLE;
      data_r  <= '0;
      key_r   <= '0;
      cnt_r   <= '0;
      msg_r   <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      fsm_r   <= fsm_nxt;
      data_r  <= data_nxt;
      key_r   <= key_nxt;
      cnt_r   <= cnt_nxt;
      msg_r   <= msg_nxt;
      valid_r <= valid_nxt;
      ready_r <= (fsm_nxt == IDLE);
      busy_r  <= (fsm_nxt != IDLE);
    end
  end

  assign o_valid = valid_r;
  assign o_msg   = msg_r;
  assign o_ready = ready_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_aes_inv_core_top.sv
// Directed bench for aes_inv_core_top using FIPS-197 vectors; follows
// AES_INV_KEY_CACHE_EN to predict latency through a small cache model.
module tb_aes_inv_core_top;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CY  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CY   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_INV_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_en;
  logic [127:0] i_cypher, i_key, o_msg;
  logic         o_valid, o_ready, busy;

  int           total = 0;
  int           bad   = 0;
  logic [127:0] m_key;
  bit           m_vld;

  always #5 clk = ~clk;

  aes_inv_core_top dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_cypher(i_cypher), .i_key(i_key),
    .o_valid(o_valid), .o_msg(o_msg), .o_ready(o_ready), .busy(busy)
  );

  function automatic int exp_lat(input logic [127:0] k);
    return (CACHE_ON && m_vld && (k == m_key)) ? 11 : 21;
  endfunction

  task automatic note_done(input logic [127:0] k);
    m_key = k;
    m_vld = 1'b1;
  endtask

  // Accepts one block and waits for o_valid; lat=999 when the bound expires.
  task automatic run_op(input logic [127:0] cy, input logic [127:0] ky, output int lat);
    i_cypher = cy;
    i_key    = ky;
    i_en     = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0;
    lat  = 999;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    i_en = 1'b0; i_cypher = '0; i_key = '0; m_vld = 1'b0; m_key = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    total++; if (o_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (o_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_msg !== 128'h0)  begin bad++; $display("FAIL reset_msg got=%h exp=0", o_msg); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_c1;
    int lat;
    run_op(C1_CY, C1_KEY, lat);
    total++; if (lat !== 21)       begin bad++; $display("FAIL c1_latency got=%0d exp=21", lat); end
    total++; if (o_msg !== C1_PT)  begin bad++; $display("FAIL c1_msg got=%h exp=%h", o_msg, C1_PT); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL c1_valid_width got=%b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL c1_ready_after got=%b exp=1", o_ready); end
    note_done(C1_KEY);
  endtask

  task automatic test_fips_appb;
    int lat, exp;
    exp = exp_lat(B_KEY);
    run_op(B_CY, B_KEY, lat);
    total++; if (lat !== exp)      begin bad++; $display("FAIL appb_latency got=%0d exp=%0d", lat, exp); end
    total++; if (o_msg !== B_PT)   begin bad++; $display("FAIL appb_msg got=%h exp=%h", o_msg, B_PT); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL appb_valid_width got=%b exp=0", o_valid); end
    note_done(B_KEY);
  endtask

  task automatic test_reset_mid;
    int lat;
    i_cypher = C1_CY; i_key = C1_KEY; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    m_vld = 1'b0;
    total++; if (o_valid !== 1'b0)  begin bad++; $display("FAIL midrst_valid got=%b exp=0", o_valid); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (o_ready !== 1'b1)  begin bad++; $display("FAIL midrst_ready got=%b exp=1", o_ready); end
    total++; if (o_msg !== 128'h0)  begin bad++; $display("FAIL midrst_msg got=%h exp=0", o_msg); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(C1_CY, C1_KEY, lat);
    total++; if (lat !== 21)        begin bad++; $display("FAIL midrst_rerun_latency got=%0d exp=21", lat); end
    total++; if (o_msg !== C1_PT)   begin bad++; $display("FAIL midrst_rerun_msg got=%h exp=%h", o_msg, C1_PT); end
    @(posedge clk); #1;
    note_done(C1_KEY);
  endtask

  task automatic test_busy_ignore;
    int lat, exp;
    bit flags_ok;
    exp = exp_lat(B_KEY);
    i_cypher = B_CY; i_key = B_KEY; i_en = 1'b1;
    @(posedge clk); #1;
    i_en = 1'b0;
    i_cypher = C1_CY; i_key = C1_KEY;
    lat = 999;
    flags_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      i_en = ((c == 5) || (c == 15));
      @(posedge clk); #1;
      if ((busy !== 1'b1) || (o_ready !== 1'b0)) flags_ok = 1'b0;
      if (o_valid) begin
        lat = c;
        break;
      end
    end
    i_en = 1'b0;
    total++; if (lat !== exp)      begin bad++; $display("FAIL busy_latency got=%0d exp=%0d", lat, exp); end
    total++; if (o_msg !== B_PT)   begin bad++; $display("FAIL busy_msg got=%h exp=%h", o_msg, B_PT); end
    total++; if (flags_ok !== 1'b1) begin bad++; $display("FAIL busy_flags got=%b exp=1", flags_ok); end
    @(posedge clk); #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL busy_idle_after got=%b exp=1", o_ready); end
    note_done(B_KEY);
  endtask

  task automatic test_back_to_back;
    int first, second, exp1;
    logic [127:0] msg1, msg2;
    bit stable_ok;
    exp1 = exp_lat(C1_KEY);
    i_cypher = C1_CY; i_key = C1_KEY; i_en = 1'b1;
    @(posedge clk); #1;
    i_cypher = B_CY; i_key = B_KEY;
    first = 0; second = 0; stable_ok = 1'b1; msg1 = '0; msg2 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        if (first == 0) begin
          first = c;
          msg1  = o_msg;
        end else begin
          second = c;
          msg2   = o_msg;
          i_en   = 1'b0;
          break;
        end
      end else if ((first != 0) && (o_msg !== C1_PT)) begin
        stable_ok = 1'b0;
      end
    end
    i_en = 1'b0;
    total++; if (first !== exp1)     begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", first, exp1); end
    total++; if (msg1 !== C1_PT)     begin bad++; $display("FAIL b2b_msg1 got=%h exp=%h", msg1, C1_PT); end
    total++; if ((second - first) !== 23) begin bad++; $display("FAIL b2b_gap got=%0d exp=23", second - first); end
    total++; if (msg2 !== B_PT)      begin bad++; $display("FAIL b2b_msg2 got=%h exp=%h", msg2, B_PT); end
    total++; if (stable_ok !== 1'b1) begin bad++; $display("FAIL b2b_msg_stable got=%b exp=1", stable_ok); end
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0)   begin bad++; $display("FAIL b2b_valid_width got=%b exp=0", o_valid); end
    note_done(B_KEY);
  endtask

  task automatic test_key_cache;
    int lat, exp;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        exp = exp_lat(C1_KEY);
        run_op(C1_CY, C1_KEY, lat);
        total++; if (o_msg !== C1_PT) begin bad++; $display("FAIL cache_msg%0d got=%h exp=%h", k, o_msg, C1_PT); end
        note_done(C1_KEY);
      end else begin
        exp = exp_lat(B_KEY);
        run_op(B_CY, B_KEY, lat);
        total++; if (o_msg !== B_PT) begin bad++; $display("FAIL cache_msg%0d got=%h exp=%h", k, o_msg, B_PT); end
        note_done(B_KEY);
      end
      total++; if (lat !== exp) begin bad++; $display("FAIL cache_latency%0d got=%0d exp=%0d", k, lat, exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_appb();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_key_cache();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
